test_monitor: RTL and testbench

//  Bus-snooping completion monitor on the CPU memory bus, downstream of the core (consumes its stores/fetches).

---
 rtl/test_monitor_pkg.sv | 20 ++
 rtl/mon_history_buf.sv | 39 +++
 rtl/test_monitor.sv | 149 ++++++++++++++
 tb/tb_test_monitor.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/test_monitor_pkg.sv
// rtl/test_monitor_pkg.sv - shared state enum, default constants and store record for test_monitor
package test_monitor_pkg;

    typedef enum logic [1:0] {
        MON_IDLE,
        MON_RUN,
        MON_DONE,
        MON_TIMEOUT
    } mon_state_t;

    localparam logic [15:0] DEFAULT_RESULT_ADDR = 16'h0080;
    localparam logic [7:0]  DEFAULT_EXPECT      = 8'h1F;
    localparam int          LOG_DEPTH           = 8;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } store_rec_t;

endpackage

// File: rtl/mon_history_buf.sv
// rtl/mon_history_buf.sv - 8-entry circular store history, index 0 reads the most recent entry
module mon_history_buf
    import test_monitor_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       wr_en_i,
    input  store_rec_t wr_rec_i,
    input  logic [2:0] rd_idx_i,
    output store_rec_t rd_rec_o,
    output logic [3:0] count_o
);

    store_rec_t mem_q [LOG_DEPTH];
    logic [2:0] wptr_q;
    logic [3:0] count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < LOG_DEPTH; i++) mem_q[i] <= '0;
        end else if (clr_i) begin
            wptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < LOG_DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en_i) begin
            mem_q[wptr_q] <= wr_rec_i;
            wptr_q        <= wptr_q + 3'd1;
            if (count_q != 4'd8) count_q <= count_q + 4'd1;
        end
    end

    // Pointer arithmetic wraps modulo 8, walking backwards from the newest entry.
    assign rd_rec_o = mem_q[wptr_q - 3'd1 - rd_idx_i];
    assign count_o  = count_q;

endmodule

// File: rtl/test_monitor.sv
// rtl/test_monitor.sv - passive bus completion monitor (result capture, trap/timeout detect); TEST_MONITOR_LOG_EN adds store history
module test_monitor
    import test_monitor_pkg::*;
#(
    parameter logic [15:0] RESULT_ADDR    = DEFAULT_RESULT_ADDR,
    parameter logic [7:0]  EXPECT         = DEFAULT_EXPECT,
    parameter int          TRAP_REPEAT    = 3,
    parameter int          TIMEOUT_CYCLES = 4096,
    parameter int          CNT_W          = 32
) (
    input  logic             ph2,
    input  logic             reset,
    input  logic             clear,
    input  logic [15:0]      addr,
    input  logic [7:0]       wdata,
    input  logic             we,
    input  logic             fetch,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [7:0]       result,
    output logic             result_valid,
    output logic [15:0]      trap_pc,
    output logic [CNT_W-1:0] cycles
`ifdef TEST_MONITOR_LOG_EN
    ,
    input  logic [2:0]       log_idx,
    output logic [15:0]      log_addr,
    output logic [7:0]       log_data,
    output logic [3:0]       log_count
`endif
);

    localparam int                REP_W   = $clog2(TRAP_REPEAT) + 1;
    localparam logic [REP_W-1:0]  REP_MAX = REP_W'(TRAP_REPEAT - 1);
    localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mon_state_t       state_q, state_d;
    logic [15:0]      last_fetch_q, last_fetch_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [7:0]       result_q, result_d;
    logic             result_valid_q, result_valid_d;
    logic [15:0]      trap_pc_q, trap_pc_d;
    logic             active;
    logic             repeat_fetch;

    assign active       = (state_q == MON_IDLE) || (state_q == MON_RUN);
    assign repeat_fetch = fetch && (addr == last_fetch_q);

    always_comb begin
        state_d        = state_q;
        last_fetch_d   = last_fetch_q;
        rep_cnt_d      = rep_cnt_q;
        cycles_d       = cycles_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        trap_pc_d      = trap_pc_q;

        // Non-fetch cycles keep rep_cnt so a JMP-self loop with gaps still counts.
        if (active && fetch) begin
            if (repeat_fetch) begin
                if (rep_cnt_q != REP_MAX) rep_cnt_d = rep_cnt_q + 1'b1;
            end else begin
                rep_cnt_d    = '0;
                last_fetch_d = addr;
            end
        end

        if (active && we && (addr == RESULT_ADDR)) begin
            result_d       = wdata;
            result_valid_d = 1'b1;
        end

        case (state_q)
            MON_IDLE: begin
                if (fetch) state_d = MON_RUN;
            end
            MON_RUN: begin
                if (cycles_q != '1) cycles_d = cycles_q + 1'b1;
                // Trap has priority over a coincident timeout.
                if (repeat_fetch && (rep_cnt_d == REP_MAX)) begin
                    state_d   = MON_DONE;
                    trap_pc_d = addr;
                end else if (cycles_q == TO_LAST) begin
                    state_d = MON_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge ph2 or posedge reset) begin
        if (reset) begin
            state_q        <= MON_IDLE;
            last_fetch_q   <= '0;
            rep_cnt_q      <= '0;
            cycles_q       <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            trap_pc_q      <= '0;
        end else if (clear) begin
            state_q        <= MON_IDLE;
            last_fetch_q   <= '0;
            rep_cnt_q      <= '0;
            cycles_q       <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            trap_pc_q      <= '0;
        end else begin
            state_q        <= state_d;
            last_fetch_q   <= last_fetch_d;
            rep_cnt_q      <= rep_cnt_d;
            cycles_q       <= cycles_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            trap_pc_q      <= trap_pc_d;
        end
    end

    assign done         = (state_q == MON_DONE);
    assign timeout      = (state_q == MON_TIMEOUT);
    assign pass         = done && result_valid_q && (result_q == EXPECT);
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign trap_pc      = trap_pc_q;
    assign cycles       = cycles_q;

`ifdef TEST_MONITOR_LOG_EN
    store_rec_t wr_rec, rd_rec;

    assign wr_rec = '{addr: addr, data: wdata};

    mon_history_buf u_hist (
        .clk_i    (ph2),
        .rst_i    (reset),
        .clr_i    (clear),
        .wr_en_i  (active && we),
        .wr_rec_i (wr_rec),
        .rd_idx_i (log_idx),
        .rd_rec_o (rd_rec),
        .count_o  (log_count)
    );

    assign log_addr = rd_rec.addr;
    assign log_data = rd_rec.data;
`endif

endmodule

// File: tb/tb_test_monitor.sv
// tb/tb_test_monitor.sv - self-checking bench for test_monitor with a reference model and directed scenarios
`timescale 1ns/1ps
module tb_test_monitor;
    import test_monitor_pkg::*;

    localparam int          TO    = 16;
    localparam int          TRAPN = 3;
    localparam logic [15:0] RADDR = 16'h0080;
    localparam logic [7:0]  EXP   = 8'h1F;

    logic        ph2 = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic        we = 1'b0;
    logic        fetch = 1'b0;
    logic        done, pass, timeout, result_valid;
    logic [7:0]  result;
    logic [15:0] trap_pc;
    logic [31:0] cycles;
`ifdef TEST_MONITOR_LOG_EN
    logic [2:0]  log_idx = '0;
    logic [15:0] log_addr;
    logic [7:0]  log_data;
    logic [3:0]  log_count;
`endif

    int checks = 0;
    int errors = 0;

    test_monitor #(.TIMEOUT_CYCLES(TO)) dut (
        .ph2(ph2), .reset(reset), .clear(clear), .addr(addr), .wdata(wdata),
        .we(we), .fetch(fetch), .done(done), .pass(pass), .timeout(timeout),
        .result(result), .result_valid(result_valid), .trap_pc(trap_pc), .cycles(cycles)
`ifdef TEST_MONITOR_LOG_EN
        , .log_idx(log_idx), .log_addr(log_addr), .log_data(log_data), .log_count(log_count)
`endif
    );

    always #5 ph2 = ~ph2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 running, 2 trapped, 3 timed out.
    int          m_phase;
    logic [15:0] m_last;
    int          m_streak;
    int          m_cycles;
    logic [7:0]  m_result;
    bit          m_rv;
    logic [15:0] m_pc;
    logic [23:0] m_log[$];

    function automatic void model_reset();
        m_phase  = 0;
        m_last   = 16'h0000;
        m_streak = 1;
        m_cycles = 0;
        m_result = 8'h00;
        m_rv     = 1'b0;
        m_pc     = 16'h0000;
        m_log.delete();
    endfunction

    function automatic void model_step();
        if (m_phase >= 2) return;
        if (we && addr == RADDR) begin
            m_result = wdata;
            m_rv     = 1'b1;
        end
        if (we) begin
            m_log.push_front({addr, wdata});
            if (m_log.size() > 8) void'(m_log.pop_back());
        end
        if (fetch) begin
            if (addr == m_last) m_streak++;
            else begin
                m_streak = 1;
                m_last   = addr;
            end
        end
        if (m_phase == 0) begin
            if (fetch) m_phase = 1;
        end else begin
            m_cycles++;
            if (fetch && m_streak >= TRAPN) begin
                m_phase = 2;
                m_pc    = addr;
            end else if (m_cycles == TO) begin
                m_phase = 3;
            end
        end
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge ph2 or posedge reset);
            if (reset || clear) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge ph2);
            chk("done", 32'(done), 32'(m_phase == 2));
            chk("timeout", 32'(timeout), 32'(m_phase == 3));
            chk("pass", 32'(pass), 32'(m_phase == 2 && m_rv && m_result == EXP));
            chk("result", 32'(result), 32'(m_result));
            chk("result_valid", 32'(result_valid), 32'(m_rv));
            chk("trap_pc", 32'(trap_pc), 32'(m_pc));
            chk("cycles", cycles, m_cycles);
`ifdef TEST_MONITOR_LOG_EN
            chk("log_count", 32'(log_count), (m_log.size() > 8) ? 8 : m_log.size());
            chk("log_rec", {8'h00, log_addr, log_data},
                {8'h00, (int'(log_idx) < m_log.size()) ? m_log[log_idx] : 24'h0});
`endif
        end
    end

    task automatic bus(input logic f, input logic [15:0] a, input logic w, input logic [7:0] d);
        fetch = f; addr = a; we = w; wdata = d;
        @(posedge ph2);
        #2;
        fetch = 1'b0; we = 1'b0; addr = 16'h0000; wdata = 8'h00;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge ph2);
        #2;
        clear = 1'b0;
    endtask

    task automatic prologue(input logic [7:0] val);
        for (int i = 0; i < 5; i++) bus(1'b1, 16'hF000 + 16'(i), 1'b0, 8'h00);
        bus(1'b0, RADDR, 1'b1, val);
    endtask

    initial begin
        repeat (2) @(posedge ph2);
        #2;
        reset = 1'b0;
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_cycles", cycles, 32'h0);

        // 1: pass case
        prologue(8'h1F);
        repeat (3) bus(1'b1, 16'hF010, 1'b0, 8'h00);
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_pass", 32'(pass), 32'h1);
        chk("t1_trap_pc", 32'(trap_pc), 32'hF010);
        chk("t1_result", 32'(result), 32'h1F);
        chk("t1_cycles", cycles, 32'd8);
        bus(1'b1, RADDR, 1'b1, 8'h00);
        bus(1'b1, 16'h1234, 1'b0, 8'h00);
        chk("t1_frozen", 32'(result), 32'h1F);

        // 2: fail value, trap loop with gaps between fetches
        do_clear();
        prologue(8'h1E);
        bus(1'b1, 16'hF010, 1'b0, 8'h00);
        bus(1'b0, 16'h0000, 1'b0, 8'h00);
        bus(1'b1, 16'hF010, 1'b0, 8'h00);
        bus(1'b0, 16'h0000, 1'b0, 8'h00);
        bus(1'b1, 16'hF010, 1'b0, 8'h00);
        chk("t2_done", 32'(done), 32'h1);
        chk("t2_pass", 32'(pass), 32'h0);
        chk("t2_result", 32'(result), 32'h1E);

        // 3: timeout
        do_clear();
        for (int i = 0; i < 21; i++) bus(1'b1, 16'h1000 + 16'(i), 1'b0, 8'h00);
        chk("t3_timeout", 32'(timeout), 32'h1);
        chk("t3_done", 32'(done), 32'h0);
        chk("t3_cycles", cycles, 32'd16);

        // 4: last write wins, other addresses ignored, simultaneous we/fetch
        do_clear();
        bus(1'b1, 16'hF000, 1'b0, 8'h00);
        bus(1'b0, RADDR, 1'b1, 8'h05);
        bus(1'b1, RADDR, 1'b1, 8'h1F);
        bus(1'b0, 16'h0081, 1'b1, 8'hAA);
        repeat (3) bus(1'b1, 16'hF010, 1'b0, 8'h00);
        chk("t4_result", 32'(result), 32'h1F);
        chk("t4_pass", 32'(pass), 32'h1);

        // 5: asynchronous reset mid-run
        do_clear();
        bus(1'b1, 16'hF000, 1'b0, 8'h00);
        bus(1'b0, RADDR, 1'b1, 8'h1F);
        bus(1'b1, 16'hF010, 1'b0, 8'h00);
        bus(1'b1, 16'hF010, 1'b0, 8'h00);
        reset = 1'b1;
        #1;
        chk("t5_async_cycles", cycles, 32'h0);
        chk("t5_async_rv", 32'(result_valid), 32'h0);
        chk("t5_async_result", 32'(result), 32'h0);
        #1;
        reset = 1'b0;
        bus(1'b1, 16'hF010, 1'b0, 8'h00);
        bus(1'b1, 16'hF010, 1'b0, 8'h00);
        chk("t5_two_fetch", 32'(done), 32'h0);
        bus(1'b1, 16'hF010, 1'b0, 8'h00);
        chk("t5_done", 32'(done), 32'h1);
        chk("t5_pass", 32'(pass), 32'h0);

        // 7: trap on the same cycle the timeout would fire
        do_clear();
        for (int i = 0; i < 14; i++) bus(1'b1, 16'h2000 + 16'(i), 1'b0, 8'h00);
        repeat (3) bus(1'b1, 16'h3000, 1'b0, 8'h00);
        chk("t7_done", 32'(done), 32'h1);
        chk("t7_timeout", 32'(timeout), 32'h0);
        chk("t7_cycles", cycles, 32'd16);

`ifdef TEST_MONITOR_LOG_EN
        // 6: store history
        do_clear();
        bus(1'b1, 16'hF000, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) bus(1'b0, 16'h0100 + 16'(i), 1'b1, 8'h10 + 8'(i));
        chk("t6_count", 32'(log_count), 32'd8);
        log_idx = 3'd0;
        #1;
        chk("t6_idx0", {8'h00, log_addr, log_data}, 32'h0001_0919);
        log_idx = 3'd7;
        #1;
        chk("t6_idx7", {8'h00, log_addr, log_data}, 32'h0001_0212);
        @(posedge ph2);
        #2;
        log_idx = 3'd0;
`endif

        repeat (2) @(posedge ph2);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
